// File: rtl/sim_run_ctrl_pkg.sv
// sim_pkg: state encoding, default run-control timing and saturating-increment helper.
// Rev 1.0
`default_nettype none

package sim_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned c_def_reset_cycles   = 4;
  localparam int unsigned c_def_timeout_cycles = 1000;
  localparam int unsigned c_def_drain_cycles   = 3;

  // Increment v, saturating at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : (v + 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if: DUT status inputs and run-control outputs of sim_run_ctrl.
// Rev 1.0
`default_nettype none

interface sim_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import sim_pkg::*;

  logic             dut_done;
  logic             dut_fail;
  logic             dut_reset;
  logic [CNT_W-1:0] cycle_count;
  state_e           state;
  logic             finish;
  logic             pass;
  logic             timed_out;

  modport master (
    input  dut_done, dut_fail,
    output dut_reset, cycle_count, state, finish, pass, timed_out
  );

  modport slave (
    output dut_done, dut_fail,
    input  dut_reset, cycle_count, state, finish, pass, timed_out
  );

endinterface

`default_nettype wire

// File: rtl/sim_run_ctrl_sat_counter.sv
// sim_sat_counter: registered up-counter with synchronous clear, enable and freeze; saturates at all-ones.
// Rev 1.0
`default_nettype none

module sim_sat_counter
  import sim_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             clear_i,
  input  wire logic             en_i,
  input  wire logic             freeze_i,
  output logic      [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !freeze_i) begin
      count_d = WIDTH'(sat_inc(64'(count_q), WIDTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences DUT reset, counts cycles, applies timeout and drain window, then requests finish.
// Rev 1.0
`default_nettype none

module sim_run_ctrl
  import sim_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned RESET_CYCLES   = c_def_reset_cycles,
  parameter int unsigned TIMEOUT_CYCLES = c_def_timeout_cycles,
  parameter int unsigned DRAIN_CYCLES   = c_def_drain_cycles
) (
  input  wire logic      clock,
  input  wire logic      reset,
  sim_run_ctrl_if.master bus
);

  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]  c_hold_last  = HOLD_W'(RESET_CYCLES - 1);
  // A zero-length drain still spends one cycle in DRAIN.
  localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [63:0]        c_timeout_last = 64'(TIMEOUT_CYCLES) - 64'd1;

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic                dut_reset_q;
  logic                finish_q;
  logic                pass_q;
  logic                timed_out_q;
  logic                fail_seen_q;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(bus.cycle_count) == c_timeout_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      drain_cnt_q <= '0;
      dut_reset_q <= 1'b1;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == c_hold_last) begin
            state_q     <= RUN;
            dut_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        RUN: begin
          // Fail outranks done, and either outranks a coincident timeout.
          if (bus.dut_fail) begin
            state_q     <= DRAIN;
            fail_seen_q <= 1'b1;
          end else if (bus.dut_done) begin
            state_q <= DRAIN;
          end else if (timeout_hit) begin
            state_q     <= DRAIN;
            timed_out_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.dut_fail) begin
            fail_seen_q <= 1'b1;
          end
          if (drain_cnt_q == c_drain_last) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            pass_q   <= !(fail_seen_q || bus.dut_fail) && !timed_out_q;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        DONE: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  sim_sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (state_q == HOLD),
    .en_i     ((state_q == RUN) || (state_q == DRAIN)),
    .freeze_i (state_q == DONE),
    .count_o  (bus.cycle_count)
  );

  assign bus.dut_reset = dut_reset_q;
  assign bus.state     = state_q;
  assign bus.finish    = finish_q;
  assign bus.pass      = pass_q;
  assign bus.timed_out = timed_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed table-driven bench for sim_run_ctrl (RESET 4, TIMEOUT 100, DRAIN 3).
// Rev 1.0
`default_nettype none

module tb_sim_run_ctrl;
  import sim_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sim_run_ctrl_if #(.CNT_W(32)) bus ();

  sim_run_ctrl #(
    .CNT_W          (32),
    .RESET_CYCLES   (4),
    .TIMEOUT_CYCLES (100),
    .DRAIN_CYCLES   (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Inputs are given in bench cycle indices k, where k equals cycle_count while in RUN.
  typedef struct {
    int done_at;
    int done_len;
    int fail_at;
    int fail_len;
    int exp_count;
    bit exp_pass;
    bit exp_to;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, 64'(bus.state), 64'(HOLD));
    chk({tag, "_dut_reset"}, 64'(bus.dut_reset), 64'd1);
    chk({tag, "_finish"}, 64'(bus.finish), 64'd0);
    chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
    chk({tag, "_timed_out"}, 64'(bus.timed_out), 64'd0);
    chk({tag, "_count"}, 64'(bus.cycle_count), 64'd0);
  endtask

  // Two reset cycles, release, then the four HOLD edges up to RUN entry.
  task automatic start_run(input string tag);
    reset        = 1'b1;
    bus.dut_done = 1'b0;
    bus.dut_fail = 1'b0;
    step();
    step();
    chk_reset_state({tag, "_rst"});
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e < 4) begin
        chk($sformatf("%s_hold%0d_dut_reset", tag, e), 64'(bus.dut_reset), 64'd1);
        chk($sformatf("%s_hold%0d_state", tag, e), 64'(bus.state), 64'(HOLD));
      end else begin
        chk({tag, "_run_dut_reset"}, 64'(bus.dut_reset), 64'd0);
        chk({tag, "_run_state"}, 64'(bus.state), 64'(RUN));
        chk({tag, "_run_count"}, 64'(bus.cycle_count), 64'd0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, output int fin_at);
    fin_at = -1;
    for (int k = 0; k < 300; k++) begin
      bus.dut_done = (k >= v.done_at) && (k < v.done_at + v.done_len);
      bus.dut_fail = (k >= v.fail_at) && (k < v.fail_at + v.fail_len);
      step();
      if (bus.finish) begin
        fin_at = k + 1;
        break;
      end
    end
    bus.dut_done = 1'b0;
    bus.dut_fail = 1'b0;
  endtask

  task automatic check_done(input string tag, input vec_t v, input int fin_at);
    chk({tag, "_finish_at"}, 64'(fin_at), 64'(v.exp_count));
    chk({tag, "_count"}, 64'(bus.cycle_count), 64'(v.exp_count));
    chk({tag, "_state"}, 64'(bus.state), 64'(DONE));
    chk({tag, "_pass"}, 64'(bus.pass), 64'(v.exp_pass));
    chk({tag, "_timed_out"}, 64'(bus.timed_out), 64'(v.exp_to));
    step();
    step();
    step();
    chk({tag, "_frozen_count"}, 64'(bus.cycle_count), 64'(v.exp_count));
    chk({tag, "_finish_held"}, 64'(bus.finish), 64'd1);
  endtask

  initial begin
    int fin;
    string tag;

    vecs[0]  = '{10, 1, -1, 0, 14, 1'b1, 1'b0};
    vecs[1]  = '{-1, 0, -1, 0, 103, 1'b0, 1'b1};
    vecs[2]  = '{20, 1, 20, 1, 24, 1'b0, 1'b0};
    vecs[3]  = '{20, 1, 22, 1, 24, 1'b0, 1'b0};
    vecs[4]  = '{99, 1, -1, 0, 103, 1'b1, 1'b0};
    vecs[5]  = '{98, 1, -1, 0, 102, 1'b1, 1'b0};
    vecs[6]  = '{0, 1, -1, 0, 4, 1'b1, 1'b0};
    vecs[7]  = '{50, 1, 53, 1, 54, 1'b0, 1'b0};
    vecs[8]  = '{10, 6, -1, 0, 14, 1'b1, 1'b0};
    vecs[9]  = '{-1, 0, 30, 20, 34, 1'b0, 1'b0};
    vecs[10] = '{-1, 0, 99, 1, 103, 1'b0, 1'b0};

    bus.dut_done = 1'b0;
    bus.dut_fail = 1'b0;

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("v%0d", i);
      start_run(tag);
      run_vec(vecs[i], fin);
      check_done(tag, vecs[i], fin);
    end

    // Reset pulse in the middle of DRAIN, then the same run must repeat exactly.
    start_run("mid");
    for (int k = 0; k < 12; k++) begin
      bus.dut_done = (k == 10);
      step();
    end
    bus.dut_done = 1'b0;
    chk("mid_in_drain", 64'(bus.state), 64'(DRAIN));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("mid_after");
    start_run("mid_rep");
    run_vec(vecs[0], fin);
    check_done("mid_rep", vecs[0], fin);

    // Reset pulse after a timed-out DONE clears the sticky verdict flags.
    start_run("post");
    run_vec(vecs[1], fin);
    check_done("post_first", vecs[1], fin);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("post_after");
    start_run("post_rep");
    run_vec(vecs[1], fin);
    check_done("post_rep", vecs[1], fin);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
